edge_event_arbiter: RTL and testbench

Multi-channel rising-edge event collector and round-robin scheduler. Each of N serial inputs runs its own three-state edge detector: IDLE, then RISE for one cycle on a 0→1 transition, then HIGH while the input stays high. Detected events are queued in per-channel saturating counters. A round-robin arbiter forwards them one at a time through a registered valid/ready port to a single shared downstream consumer. The block sits between the asynchronous-to-design-rate input sampling stage and the event-processing datapath.

---
 rtl/edge_event_arbiter_if.sv | 21 ++
 rtl/edge_event_arbiter.sv | 125 ++++++++++++
 tb/tb_edge_event_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_event_arbiter_if.sv
// Event output channel between the edge arbiter and its consumer.
// Producer drives valid/ch, consumer drives ready.
interface edge_event_arbiter_if #(
    parameter int CH_W = 2
);
    logic            out_valid;
    logic            out_ready;
    logic [CH_W-1:0] out_ch;

    modport master (
        output out_valid,
        output out_ch,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_ch,
        output out_ready
    );
endinterface

// File: rtl/edge_event_arbiter.sv
// Per-channel rising-edge detectors feeding saturating pending counters,
// drained one event at a time by a round-robin arbiter into a registered port.
module edge_event_arbiter #(
    parameter int N     = 4,
    parameter int CH_W  = 2,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in,
    edge_event_arbiter_if.master out_bus,
    output logic [N-1:0]         ovf,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RISE = 2'b01,
        S_HIGH = 2'b10
    } det_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CH_W-1:0]  PTR_RST = CH_W'(N - 1);

    det_e             st_q [N];
    det_e             st_d [N];
    logic [N-1:0]     ev;
    logic [CNT_W-1:0] pend_q [N];
    logic [N-1:0]     has;
    logic [N-1:0]     ld;

    logic            valid_q;
    logic [CH_W-1:0] ch_q;
    logic [CH_W-1:0] ptr_q;
    logic            free;
    logic            found;
    logic [CH_W-1:0] sel;
    logic            load;

    // Edge detector state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) st_q[i] <= S_IDLE;
        end else begin
            for (int i = 0; i < N; i++) st_q[i] <= st_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            st_d[i] = S_IDLE;
            ev[i]   = 1'b0;
            case (st_q[i])
                S_IDLE: st_d[i] = in[i] ? S_RISE : S_IDLE;
                S_RISE: st_d[i] = in[i] ? S_HIGH : S_IDLE;
                S_HIGH: st_d[i] = in[i] ? S_HIGH : S_IDLE;
                default: st_d[i] = S_IDLE;
            endcase
            ev[i] = (st_q[i] == S_RISE);
        end
    end

    // Round-robin search starting just after the last granted channel
    always_comb begin
        int              j;
        logic [CH_W-1:0] idx;
        j     = 0;
        idx   = '0;
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < N; i++) has[i] = (pend_q[i] != '0);
        for (int k = 1; k <= N; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N) j = j - N;
            idx = CH_W'(j);
            if (!found && has[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign free = !valid_q || out_bus.out_ready;
    assign load = free && found;

    always_comb begin
        for (int i = 0; i < N; i++) ld[i] = load && (sel == CH_W'(i));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            ch_q    <= '0;
            ptr_q   <= PTR_RST;
        end else if (free) begin
            valid_q <= found;
            if (found) begin
                ch_q  <= sel;
                ptr_q <= sel;
            end
        end
    end

    // A simultaneous event and load cancel, so a full counter never overflows then
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) pend_q[i] <= '0;
            ovf <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (ev[i] && !ld[i]) begin
                    if (pend_q[i] == CNT_MAX) ovf[i] <= 1'b1;
                    else pend_q[i] <= pend_q[i] + 1'b1;
                end else if (!ev[i] && ld[i]) begin
                    pend_q[i] <= pend_q[i] - 1'b1;
                end
            end
        end
    end

    assign out_bus.out_valid = valid_q;
    assign out_bus.out_ch    = ch_q;
    assign busy              = valid_q || (|has);

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: vector table for reset/latency,
// scripted sequences for level hold, overflow, fairness and collisions.
module tb_edge_event_arbiter;

    localparam int N     = 4;
    localparam int CH_W  = 2;
    localparam int CNT_W = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    in  = '0;
    logic [N-1:0]    ovf;
    logic            busy;

    edge_event_arbiter_if #(.CH_W(CH_W)) ob ();

    edge_event_arbiter #(
        .N    (N),
        .CH_W (CH_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .in     (in),
        .out_bus(ob),
        .ovf    (ovf),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int xfers    = 0;
    int exp_q[$];

    logic            prev_stall = 1'b0;
    logic [CH_W-1:0] prev_ch    = '0;

    typedef struct {
        logic            r;
        logic [N-1:0]    i;
        logic            rdy;
        logic            v;
        logic [CH_W-1:0] ch;
        logic            b;
        logic [N-1:0]    o;
    } vec_t;

    vec_t tv [15];

    // Transfer scoreboard and stall-stability monitor
    always @(negedge clk) begin
        if (prev_stall) begin
            checks++;
            if (!ob.out_valid || ob.out_ch != prev_ch) begin
                failures++;
                $display("FAIL stall valid=%0b ch=%0d required valid=1 ch=%0d",
                         ob.out_valid, ob.out_ch, prev_ch);
            end
        end
        prev_stall = rst && ob.out_valid && !ob.out_ready;
        prev_ch    = ob.out_ch;
        if (rst && ob.out_valid && ob.out_ready) begin
            xfers++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL xfer unexpected ch=%0d required none", ob.out_ch);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(ob.out_ch) != e) begin
                    failures++;
                    $display("FAIL xfer ch=%0d required %0d", ob.out_ch, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic pulse(input logic [N-1:0] m);
        in = m;
        step();
        in = '0;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in  = '0;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 100) begin
            step();
            n++;
        end
        chk({nm, "_drain_timeout"}, n >= 100 ? 1 : 0, 0);
    endtask

    initial begin
        int x0;

        tv[0]  = '{1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0};
        tv[1]  = '{1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0};
        tv[2]  = '{1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0};
        tv[3]  = '{1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0};
        tv[4]  = '{1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 1'b1, 4'h0};
        tv[5]  = '{1'b1, 4'hF, 1'b1, 1'b1, 2'd0, 1'b1, 4'h0};
        tv[6]  = '{1'b1, 4'hF, 1'b1, 1'b1, 2'd1, 1'b1, 4'h0};
        tv[7]  = '{1'b1, 4'hF, 1'b1, 1'b1, 2'd2, 1'b1, 4'h0};
        tv[8]  = '{1'b1, 4'hF, 1'b1, 1'b1, 2'd3, 1'b1, 4'h0};
        tv[9]  = '{1'b1, 4'h0, 1'b1, 1'b0, 2'd3, 1'b0, 4'h0};
        tv[10] = '{1'b1, 4'h0, 1'b1, 1'b0, 2'd3, 1'b0, 4'h0};
        tv[11] = '{1'b1, 4'h4, 1'b1, 1'b0, 2'd3, 1'b0, 4'h0};
        tv[12] = '{1'b1, 4'h0, 1'b1, 1'b0, 2'd3, 1'b1, 4'h0};
        tv[13] = '{1'b1, 4'h0, 1'b1, 1'b1, 2'd2, 1'b1, 4'h0};
        tv[14] = '{1'b1, 4'h0, 1'b1, 1'b0, 2'd2, 1'b0, 4'h0};

        ob.out_ready = 1'b0;

        // Reset with inputs high, release, then a single-pulse latency run
        for (int k = 0; k < 15; k++) begin
            if (k == 3) begin
                exp_q.push_back(0);
                exp_q.push_back(1);
                exp_q.push_back(2);
                exp_q.push_back(3);
            end
            if (k == 11) exp_q.push_back(2);
            rst          = tv[k].r;
            in           = tv[k].i;
            ob.out_ready = tv[k].rdy;
            step();
            chk($sformatf("tv%0d_valid", k), int'(ob.out_valid), int'(tv[k].v));
            chk($sformatf("tv%0d_ch", k), int'(ob.out_ch), int'(tv[k].ch));
            chk($sformatf("tv%0d_busy", k), int'(busy), int'(tv[k].b));
            chk($sformatf("tv%0d_ovf", k), int'(ovf), int'(tv[k].o));
        end
        chk("reset_hold_xfers", xfers, 5);

        // Level hold produces one event
        x0 = xfers;
        exp_q.push_back(1);
        in = 4'b0010;
        repeat (10) step();
        in = '0;
        wait_idle("level");
        chk("level_xfers", xfers - x0, 1);

        // Backpressure and overflow on ch0
        x0 = xfers;
        ob.out_ready = 1'b0;
        repeat (8) exp_q.push_back(0);
        repeat (8) pulse(4'b0001);
        step();
        step();
        chk("ovf_before", int'(ovf), 0);
        chk("stall_valid", int'(ob.out_valid), 1);
        chk("stall_ch", int'(ob.out_ch), 0);
        pulse(4'b0001);
        step();
        step();
        chk("ovf_after", int'(ovf), 1);
        ob.out_ready = 1'b1;
        wait_idle("ovf");
        chk("ovf_xfers", xfers - x0, 8);
        chk("ovf_sticky", int'(ovf), 1);

        // Reset mid-operation discards the presented and pending events
        ob.out_ready = 1'b0;
        pulse(4'b0100);
        pulse(4'b0100);
        step();
        chk("pre_rst_valid", int'(ob.out_valid), 1);
        do_reset();
        chk("mid_rst_valid", int'(ob.out_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ovf", int'(ovf), 0);

        // Fairness between ch0 and ch3
        x0 = xfers;
        exp_q.push_back(0);
        exp_q.push_back(3);
        exp_q.push_back(0);
        exp_q.push_back(3);
        exp_q.push_back(0);
        exp_q.push_back(3);
        repeat (3) pulse(4'b1001);
        step();
        step();
        ob.out_ready = 1'b1;
        wait_idle("fair");
        chk("fair_xfers", xfers - x0, 6);

        // Event on ch1 in the same cycle ch1 is loaded while full
        do_reset();
        x0 = xfers;
        ob.out_ready = 1'b0;
        repeat (9) exp_q.push_back(1);
        repeat (8) pulse(4'b0010);
        step();
        step();
        in = 4'b0010;
        step();
        ob.out_ready = 1'b1;
        in = '0;
        step();
        ob.out_ready = 1'b0;
        step();
        step();
        chk("coll_ovf", int'(ovf), 0);
        chk("coll_valid", int'(ob.out_valid), 1);
        chk("coll_ch", int'(ob.out_ch), 1);
        ob.out_ready = 1'b1;
        wait_idle("coll");
        chk("coll_xfers", xfers - x0, 9);
        chk("coll_ovf_end", int'(ovf), 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
